// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 fetch-side program-counter logic.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package mips_pkg;

  // Default vectors; the top exposes these as overridable parameters.
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

  // PC sequencing state.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_t;

  // Which source won the next-PC priority mux.
  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } next_pc_sel_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Control-transfer inputs and PC outputs of the program-counter stage.
// Latency: n/a (wiring only).
// Backpressure: stall is the only hold signal; no valid/ready on redirects.
// Ports: master drives stall/redirects and observes the PC; slave is the PC unit.
interface pc_next_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jump_reg;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        addr_exc;
  logic [31:0] exc_epc;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           jump_reg, jr_target,
    input  pc, pc_plus4, pc_valid, addr_exc, exc_epc
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           jump_reg, jr_target,
    output pc, pc_plus4, pc_valid, addr_exc, exc_epc
  );
endinterface

// File: rtl/next_pc_select.sv
// Fixed-priority next-PC mux (JR > J > branch > sequential) with alignment check.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is consumed.
// Ports: pc_plus4_i and the three redirect request/target pairs in;
//        winning target, redirect flag and misaligned flag out.
module next_pc_select
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        jump_reg_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] sel_target_o,
  output logic        sel_is_redirect_o,
  output logic        sel_misaligned_o
);

  next_pc_sel_t sel;

  always_comb begin
    sel = SEL_SEQ;
    if (jump_reg_i)          sel = SEL_JR;
    else if (jump_i)         sel = SEL_J;
    else if (branch_taken_i) sel = SEL_BR;
  end

  always_comb begin
    sel_target_o = pc_plus4_i;
    case (sel)
      SEL_JR:  sel_target_o = jr_target_i;
      SEL_J:   sel_target_o = jump_target_i;
      SEL_BR:  sel_target_o = branch_target_i;
      default: sel_target_o = pc_plus4_i;
    endcase
  end

  assign sel_is_redirect_o = (sel != SEL_SEQ);
  // pc_plus4 is always aligned, so only redirects can trap.
  assign sel_misaligned_o  = sel_is_redirect_o && is_misaligned(sel_target_o);

endmodule

// File: rtl/pc_next_unit.sv
// Architectural PC register with stall hold, one-entry pending redirect and
// misaligned-target trap to EXC_VECTOR.
// Latency: one cycle from redirect/sequential selection to pc.
// Backpressure: stall freezes pc; redirects seen while stalled are buffered
//   (last one wins) and applied on release.
// Ports: clk, reset (sync, active high); bus = pc_next_unit_if slave modport.
module pc_next_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_next_unit_if.slave        bus
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic [31:0] pc_plus4;
  logic [31:0] sel_target;
  logic        sel_is_redirect;
  logic        sel_misaligned;

  // Per-cycle update request: load tgt into pc, or trap if tgt_trap.
  logic        advance;
  logic [31:0] tgt;
  logic        tgt_trap;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_select u_sel (
    .pc_plus4_i        (pc_plus4),
    .branch_taken_i    (bus.branch_taken),
    .branch_target_i   (bus.branch_target),
    .jump_i            (bus.jump),
    .jump_target_i     (bus.jump_target),
    .jump_reg_i        (bus.jump_reg),
    .jr_target_i       (bus.jr_target),
    .sel_target_o      (sel_target),
    .sel_is_redirect_o (sel_is_redirect),
    .sel_misaligned_o  (sel_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    advance     = 1'b0;
    tgt         = sel_target;
    tgt_trap    = sel_misaligned;

    case (state_q)
      BOOT: begin
        // Stall and redirects are ignored during the single boot cycle.
        state_d = RUN;
      end
      RUN, HOLD: begin
        if (bus.stall) begin
          state_d = HOLD;
          if (sel_is_redirect) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = sel_target;
          end
        end else begin
          state_d = RUN;
          advance = 1'b1;
          // A buffered redirect takes precedence over this cycle's inputs.
          if (pend_vld_q) begin
            pend_vld_d = 1'b0;
            tgt        = pend_addr_q;
            tgt_trap   = is_misaligned(pend_addr_q);
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    exc_d = 1'b0;
    epc_d = epc_q;
    if (advance) begin
      if (tgt_trap) begin
        pc_d  = EXC_VECTOR;
        exc_d = 1'b1;
        epc_d = tgt;
      end else begin
        pc_d = tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      exc_q       <= 1'b0;
      epc_q       <= 32'h0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      exc_q       <= exc_d;
      epc_q       <= epc_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.pc_valid = (state_q != BOOT);
  assign bus.addr_exc = exc_q;
  assign bus.exc_epc  = epc_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit with a queue-based scoreboard.
// Each stimulus cycle pushes the outputs expected after the next rising edge;
// a separate monitor pops and compares shortly after every edge.
module tb_pc_next_unit;

  logic clk;
  logic reset;

  pc_next_unit_if bus_if ();

  pc_next_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic        exc;
    logic [31:0] epc;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: compare the DUT outputs against the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, ".pc"},       bus_if.pc,                e.pc);
        chk({e.tag, ".pc_plus4"}, bus_if.pc_plus4,          e.pc + 32'd4);
        chk({e.tag, ".pc_valid"}, {31'd0, bus_if.pc_valid}, {31'd0, e.vld});
        chk({e.tag, ".addr_exc"}, {31'd0, bus_if.addr_exc}, {31'd0, e.exc});
        chk({e.tag, ".exc_epc"},  bus_if.exc_epc,           e.epc);
      end
    end
  end

  // Drive one cycle of inputs (away from the rising edge) and queue the
  // outputs expected after that edge.
  task automatic cyc(
    input string       tag,
    input logic        rst,
    input logic        stl,
    input logic        br,  input logic [31:0] brt,
    input logic        j,   input logic [31:0] jt,
    input logic        jr,  input logic [31:0] jrt,
    input logic [31:0] e_pc,
    input logic        e_vld,
    input logic        e_exc,
    input logic [31:0] e_epc
  );
    exp_t e;
    @(negedge clk);
    reset                = rst;
    bus_if.stall         = stl;
    bus_if.branch_taken  = br;
    bus_if.branch_target = brt;
    bus_if.jump          = j;
    bus_if.jump_target   = jt;
    bus_if.jump_reg      = jr;
    bus_if.jr_target     = jrt;
    e.pc  = e_pc;
    e.vld = e_vld;
    e.exc = e_exc;
    e.epc = e_epc;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  initial begin
    reset                = 1'b1;
    bus_if.stall         = 1'b0;
    bus_if.branch_taken  = 1'b0;
    bus_if.branch_target = 32'h0;
    bus_if.jump          = 1'b0;
    bus_if.jump_target   = 32'h0;
    bus_if.jump_reg      = 1'b0;
    bus_if.jr_target     = 32'h0;

    //   tag          rst stl br brt            j  jt             jr jrt          pc             vld exc epc
    cyc("rst0",       1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0000, 0, 0, 32'h0);
    cyc("rst1",       1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0000, 0, 0, 32'h0);
    cyc("boot",       0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0000, 1, 0, 32'h0);
    cyc("seq4",       0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0004, 1, 0, 32'h0);
    cyc("seq8",       0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0008, 1, 0, 32'h0);
    cyc("seq12",      0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_000C, 1, 0, 32'h0);
    cyc("jmp_a",      0, 0, 0, 32'h0,         1, 32'h0040_0010, 0, 32'h0,      32'h0040_0010, 1, 0, 32'h0);
    // jump outranks branch
    cyc("j_gt_br",    0, 0, 1, 32'h0050_0000, 1, 32'h0040_1000, 0, 32'h0,      32'h0040_1000, 1, 0, 32'h0);
    // JR outranks J; misaligned JR target traps
    cyc("jr_trap",    0, 0, 0, 32'h0,         1, 32'h0000_3000, 1, 32'h2002,   32'h0000_0080, 1, 1, 32'h0000_2002);
    cyc("after_trap", 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0084, 1, 0, 32'h0000_2002);
    // Stall 3 cycles, branch only in the first
    cyc("stall1",     0, 1, 1, 32'h0000_0100, 0, 32'h0,         0, 32'h0,      32'h0000_0084, 1, 0, 32'h0000_2002);
    cyc("stall2",     0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0084, 1, 0, 32'h0000_2002);
    cyc("stall3",     0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0084, 1, 0, 32'h0000_2002);
    // Release: pending wins, this cycle's jump is ignored
    cyc("release",    0, 0, 0, 32'h0,         1, 32'h0000_4000, 0, 32'h0,      32'h0000_0100, 1, 0, 32'h0000_2002);
    cyc("post_rel",   0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0104, 1, 0, 32'h0000_2002);
    // Pending overwritten (last wins), misaligned pending traps on release
    cyc("pstall1",    0, 1, 1, 32'h0000_0201, 0, 32'h0,         0, 32'h0,      32'h0000_0104, 1, 0, 32'h0000_2002);
    cyc("pstall2",    0, 1, 0, 32'h0,         1, 32'h0000_0302, 0, 32'h0,      32'h0000_0104, 1, 0, 32'h0000_2002);
    cyc("ptrap",      0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0080, 1, 1, 32'h0000_0302);
    cyc("post_ptrap", 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0084, 1, 0, 32'h0000_0302);
    // Two traps back to back
    cyc("trap_a",     0, 0, 1, 32'h0000_0011, 0, 32'h0,         0, 32'h0,      32'h0000_0080, 1, 1, 32'h0000_0011);
    cyc("trap_b",     0, 0, 1, 32'h0000_0023, 0, 32'h0,         0, 32'h0,      32'h0000_0080, 1, 1, 32'h0000_0023);
    cyc("post_b2b",   0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0084, 1, 0, 32'h0000_0023);
    // Wrap: pc_plus4 of FFFF_FFFC is 0, sequential fetch does not trap
    cyc("to_top",     0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,      32'hFFFF_FFFC, 1, 0, 32'h0000_0023);
    cyc("wrap",       0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0000, 1, 0, 32'h0000_0023);
    // HOLD release with empty buffer uses normal selection
    cyc("hstall",     0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0000, 1, 0, 32'h0000_0023);
    cyc("hrel_br",    0, 0, 1, 32'h0000_0040, 0, 32'h0,         0, 32'h0,      32'h0000_0040, 1, 0, 32'h0000_0023);
    // Reset in the second stall cycle with a redirect pending
    cyc("rstall1",    0, 1, 1, 32'h0000_0500, 0, 32'h0,         0, 32'h0,      32'h0000_0040, 1, 0, 32'h0000_0023);
    cyc("rstall2",    1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0000, 0, 0, 32'h0);
    // Stall during boot is ignored
    cyc("boot_stl",   0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0000, 1, 0, 32'h0);
    cyc("rboot4",     0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0004, 1, 0, 32'h0);
    cyc("rboot8",     0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,      32'h0000_0008, 1, 0, 32'h0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
